// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the PRBS31 transmit generator:
//   - polynomial constants (G(x) = x^31 + x^28 + 1) and output word width
//   - default (all-ones) seed used after reset, for seed=0 and for lock-up recovery
//   - injection-mode and generator-FSM enumerations
//   - decode_mode(): maps the raw 2-bit mode input onto inj_mode_t (11 -> off)
// ---------------------------------------------------------------------------
package prbs_pkg;

    localparam int PRBS31_LEN = 31;
    localparam int TAP_A      = 31;
    localparam int TAP_B      = 28;
    localparam int WORD_W     = 64;

    localparam logic [PRBS31_LEN-1:0] PRBS31_DEFAULT_SEED = 31'h7FFF_FFFF;

    typedef enum logic [1:0] {
        INJ_OFF      = 2'b00,
        INJ_SINGLE   = 2'b01,
        INJ_PERIODIC = 2'b10
    } inj_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gen_state_t;

    // The reserved encoding 2'b11 behaves exactly like "off".
    function automatic inj_mode_t decode_mode(input logic [1:0] mode_raw);
        inj_mode_t m;
        case (mode_raw)
            2'b01:   m = INJ_SINGLE;
            2'b10:   m = INJ_PERIODIC;
            default: m = INJ_OFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/prbs31_next64.sv
// ---------------------------------------------------------------------------
// prbs31_next64
// Purely combinational look-ahead of the PRBS31 stream by one 64-bit word.
// Ports:
//   S    [30:0] in   current state, S[j] = d[n-31+j] (S[0] is the oldest bit)
//   next [63:0] out  the next 64 stream bits, next[i] = d[n+i] (bit 0 first)
// The new state after this word is next[63:33] (the 31 most recent bits).
// ---------------------------------------------------------------------------
module prbs31_next64
    import prbs_pkg::*;
(
    input  logic [PRBS31_LEN-1:0] S,
    output logic [WORD_W-1:0]     next
);

    // Extended stream: the 31 state bits followed by the 64 new bits. Each new
    // bit d[n] = d[n-31] ^ d[n-28]; unrolling the loop yields a flat XOR network.
    logic [PRBS31_LEN+WORD_W-1:0] w_ext;

    always_comb begin
        w_ext = '0;
        w_ext[PRBS31_LEN-1:0] = S;
        for (int i = 0; i < WORD_W; i++) begin
            w_ext[PRBS31_LEN+i] = w_ext[i+PRBS31_LEN-TAP_A] ^ w_ext[i+PRBS31_LEN-TAP_B];
        end
    end

    assign next = w_ext[PRBS31_LEN+WORD_W-1:PRBS31_LEN];

endmodule

// File: rtl/prbs31_gen_tx.sv
// ---------------------------------------------------------------------------
// prbs31_gen_tx
// 64-bit parallel PRBS31 generator for a serial transmitter, with optional
// single-bit error injection (single-shot or periodic).
// Ports:
//   clk_390p625M        in   system clock (rising edge)
//   rst_n               in   asynchronous active-low reset
//   gen_EN              in   generator enable; low freezes all sequence state
//   seed_load           in   one-cycle pulse, loads seed (0 -> all-ones)
//   seed [30:0]         in   seed value
//   err_inj_mode [1:0]  in   00 off, 01 single-shot, 10 periodic, 11 off
//   err_inj_req         in   single-shot trigger pulse
//   err_inj_pos [5:0]   in   bit of the output word inverted on injection
//   err_period [15:0]   in   periodic interval in valid words (0 acts as 1)
//   data_to_TX [63:0]   out  PRBS word, bit 0 first in time
//   data_valid          out  data_to_TX holds a new word this cycle
//   err_inj_ack         out  marks the word carrying an injected error
//   inj_err_count[15:0] out  saturating count of injected errors
// ---------------------------------------------------------------------------
module prbs31_gen_tx
    import prbs_pkg::*;
(
    input  logic        clk_390p625M,
    input  logic        rst_n,
    input  logic        gen_EN,
    input  logic        seed_load,
    input  logic [30:0] seed,
    input  logic [1:0]  err_inj_mode,
    input  logic        err_inj_req,
    input  logic [5:0]  err_inj_pos,
    input  logic [15:0] err_period,
    output logic [63:0] data_to_TX,
    output logic        data_valid,
    output logic        err_inj_ack,
    output logic [15:0] inj_err_count
);

    gen_state_t              r_fsm;
    gen_state_t              w_fsm_next;
    logic [PRBS31_LEN-1:0]   r_s;
    logic [WORD_W-1:0]       r_data;
    logic                    r_valid;
    logic                    r_ack;
    logic [15:0]             r_inj_cnt;
    logic [15:0]             r_per_cnt;
    logic                    r_pend;
    inj_mode_t               r_mode_q;
    logic [15:0]             r_period_q;

    logic [WORD_W-1:0]       w_next;
    logic [WORD_W-1:0]       w_mask;
    inj_mode_t               w_mode;
    logic [15:0]             w_period_eff;
    logic                    w_lockup;
    logic                    w_gen;
    logic                    w_cfg_chg;
    logic                    w_pend_eff;
    logic                    w_per_hit;
    logic                    w_inj;

    prbs31_next64 u_next64 (
        .S    (r_s),
        .next (w_next)
    );

    // One-hot injection mask selected by err_inj_pos.
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_mask
        assign w_mask[gi] = (err_inj_pos == 6'(gi));
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        w_gen      = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (gen_EN) w_fsm_next = RUN;
            end
            RUN: begin
                if (!gen_EN) w_fsm_next = IDLE;
                // A seed load or lock-up recovery consumes the cycle: no word.
                w_gen = gen_EN && !seed_load && !w_lockup;
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    // ---------------- injection decision ----------------
    assign w_mode       = decode_mode(err_inj_mode);
    assign w_period_eff = (err_period == 16'd0) ? 16'd1 : err_period;
    assign w_lockup     = (r_s == '0);
    // Any configuration change discards the period phase and a pending shot.
    assign w_cfg_chg    = (w_mode != r_mode_q) || (err_period != r_period_q);
    // A request in the same cycle as a word lands on that word.
    assign w_pend_eff   = r_pend || ((w_mode == INJ_SINGLE) && err_inj_req);
    assign w_per_hit    = (r_per_cnt == (w_period_eff - 16'd1));
    assign w_inj        = w_gen && !w_cfg_chg &&
                          (((w_mode == INJ_SINGLE) && w_pend_eff) ||
                           ((w_mode == INJ_PERIODIC) && w_per_hit));

    // ---------------- datapath ----------------
    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            r_s        <= PRBS31_DEFAULT_SEED;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ack      <= 1'b0;
            r_inj_cnt  <= '0;
            r_per_cnt  <= '0;
            r_pend     <= 1'b0;
            r_mode_q   <= INJ_OFF;
            r_period_q <= '0;
        end else begin
            r_mode_q   <= w_mode;
            r_period_q <= err_period;

            // Sequence state only ever follows the clean stream; the
            // injected bit is applied to the output register alone.
            if (seed_load) begin
                r_s <= (seed == '0) ? PRBS31_DEFAULT_SEED : seed;
            end else if (w_lockup) begin
                r_s <= PRBS31_DEFAULT_SEED;
            end else if (w_gen) begin
                r_s <= w_next[WORD_W-1:WORD_W-PRBS31_LEN];
            end

            r_valid <= w_gen;
            r_ack   <= w_inj;
            if (w_gen) begin
                r_data <= w_inj ? (w_next ^ w_mask) : w_next;
            end

            if (w_cfg_chg) begin
                r_per_cnt <= '0;
                r_pend    <= 1'b0;
            end else begin
                r_pend <= (w_mode == INJ_SINGLE) && w_pend_eff && !w_gen;
                if (w_gen && (w_mode == INJ_PERIODIC)) begin
                    r_per_cnt <= w_per_hit ? 16'd0 : (r_per_cnt + 16'd1);
                end
            end

            if (w_inj && (r_inj_cnt != 16'hFFFF)) begin
                r_inj_cnt <= r_inj_cnt + 16'd1;
            end
        end
    end

    assign data_to_TX    = r_data;
    assign data_valid    = r_valid;
    assign err_inj_ack   = r_ack;
    assign inj_err_count = r_inj_cnt;

endmodule

// File: tb/tb_prbs31_gen_tx.sv
`timescale 1ns/1ps
module tb_prbs31_gen_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        gen_EN = 1'b0;
    logic        seed_load = 1'b0;
    logic [30:0] seed = '0;
    logic [1:0]  err_inj_mode = 2'b00;
    logic        err_inj_req = 1'b0;
    logic [5:0]  err_inj_pos = '0;
    logic [15:0] err_period = '0;
    logic [63:0] data_to_TX;
    logic        data_valid;
    logic        err_inj_ack;
    logic [15:0] inj_err_count;

    localparam logic [63:0] FIRST_WORD = 64'h3F00_0000_7000_0000;

    prbs31_gen_tx dut (
        .clk_390p625M  (clk),
        .rst_n         (rst_n),
        .gen_EN        (gen_EN),
        .seed_load     (seed_load),
        .seed          (seed),
        .err_inj_mode  (err_inj_mode),
        .err_inj_req   (err_inj_req),
        .err_inj_pos   (err_inj_pos),
        .err_period    (err_period),
        .data_to_TX    (data_to_TX),
        .data_valid    (data_valid),
        .err_inj_ack   (err_inj_ack),
        .inj_err_count (inj_err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        ack;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model state: bit-serial LFSR plus injection bookkeeping.
    logic [30:0] m_s = '1;
    bit          m_run = 0;
    int          m_mode = 0;
    int          m_period = 1;
    bit          m_pend = 0;
    int          m_wcnt = 0;
    int          m_cnt = 0;
    int          m_pos = 0;
    logic [63:0] last_exp = '0;

    function void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] model_word();
        logic [63:0] w;
        logic        b;
        w = '0;
        for (int i = 0; i < 64; i++) begin
            b    = m_s[0] ^ m_s[3];
            w[i] = b;
            m_s  = {b, m_s[30:1]};
        end
        return w;
    endfunction

    // Drive one clock cycle of stimulus; push the expected word if one is due.
    task automatic step(input bit en, input bit sl = 0, input logic [30:0] sd = '0,
                        input bit req = 0);
        logic [63:0] w;
        bit          inj;
        gen_EN      = en;
        seed_load   = sl;
        seed        = sd;
        err_inj_req = req;
        if (req && m_mode == 1) m_pend = 1;
        if (sl) begin
            m_s = (sd == '0) ? 31'h7FFF_FFFF : sd;
        end else if (m_run && en) begin
            w   = model_word();
            inj = 0;
            if (m_mode == 1 && m_pend) begin
                inj    = 1;
                m_pend = 0;
            end else if (m_mode == 2) begin
                inj = (((m_wcnt + 1) % m_period) == 0);
                m_wcnt++;
            end
            if (inj) begin
                w = w ^ (64'd1 << m_pos);
                if (m_cnt < 65535) m_cnt++;
            end
            last_exp = w;
            sb_q.push_back('{data: w, ack: inj, cnt: 16'(m_cnt)});
        end
        m_run = en;
        @(posedge clk);
        #1;
        seed_load   = 1'b0;
        err_inj_req = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] mode, input logic [15:0] per, input int pos);
        err_inj_mode = mode;
        err_period   = per;
        err_inj_pos  = 6'(pos);
        m_mode   = (mode == 2'b01) ? 1 : ((mode == 2'b10) ? 2 : 0);
        m_period = (per == 16'd0) ? 1 : int'(per);
        m_pend   = 0;
        m_wcnt   = 0;
        m_pos    = pos;
        step(0);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_s   = '1;
        m_run = 0;
        m_pend = 0;
        m_wcnt = 0;
        m_cnt  = 0;
    endtask

    // Monitor: every valid word is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (data_valid) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %h expected none (t=%0t)", data_to_TX, $time);
                    end else begin
                        e = sb_q.pop_front();
                        chk("word", data_to_TX, e.data);
                        chk("ack", 64'(err_inj_ack), 64'(e.ack));
                        chk("count", 64'(inj_err_count), 64'(e.cnt));
                    end
                end else begin
                    chk("ack_idle", 64'(err_inj_ack), 64'd0);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset state ----
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data_to_TX, 64'd0);
        chk("rst_valid", 64'(data_valid), 64'd0);
        chk("rst_ack", 64'(err_inj_ack), 64'd0);
        chk("rst_count", 64'(inj_err_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // ---- first word after enable, then clean run ----
        step(1);
        chk("idle_no_valid", 64'(data_valid), 64'd0);
        step(1);
        chk("first_word", data_to_TX, FIRST_WORD);
        chk("first_valid", 64'(data_valid), 64'd1);
        repeat (2000) step(1);
        step(0);
        chk("hold_data", data_to_TX, last_exp);
        chk("hold_valid", 64'(data_valid), 64'd0);

        // ---- seed loads: zero seed acts as all-ones ----
        step(1);
        step(1, 1, 31'd0);
        chk("seed_no_word", 64'(data_valid), 64'd0);
        step(1);
        chk("seed0_word", data_to_TX, FIRST_WORD);
        step(1, 1, 31'h1234_5678);
        repeat (100) step(1);

        // ---- single-shot, bit 5; second request while armed is ignored ----
        set_mode(2'b01, 16'd0, 5);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(1);
        repeat (10) step(1);
        chk("single_count", 64'(inj_err_count), 64'd1);

        // ---- periodic every 4 words, paused 3 cycles mid-run ----
        set_mode(2'b10, 16'd4, 63);
        step(1);
        repeat (8) step(1);
        repeat (3) step(0);
        step(1);
        repeat (8) step(1);
        chk("periodic_count", 64'(inj_err_count), 64'd5);

        // ---- period 0 acts as 1: every word injected until saturation ----
        set_mode(2'b10, 16'd0, 0);
        step(1);
        repeat (65540) step(1);
        chk("sat_count", 64'(inj_err_count), 64'hFFFF);

        // ---- asynchronous reset mid-run ----
        set_mode(2'b00, 16'd0, 0);
        step(1);
        repeat (20) step(1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", data_to_TX, 64'd0);
        chk("arst_valid", 64'(data_valid), 64'd0);
        chk("arst_ack", 64'(err_inj_ack), 64'd0);
        chk("arst_count", 64'(inj_err_count), 64'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1);
        step(1);
        chk("rst_restart_word", data_to_TX, FIRST_WORD);
        repeat (50) step(1);
        repeat (3) step(0);

        @(negedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
